// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - instruction sequencer driving the 34-bit inst bus of core
//
// Runs one full convolution pass per kernel position kij, then the pmem-read /
// accumulate phase that feeds the SFU once per output pixel.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      start request, sampled only while idle
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse at the end of the sequence
//   core_rst   reset to core (PE / FIFO / SFU accumulator clear)
//   out_valid  one-cycle pulse: core sfu_out holds output pixel onij
//   onij       index of the output pixel, valid with out_valid
//   inst       core instruction word
//              [33]acc [32]CEN_p [31]WEN_p [30:20]A_p [19]CEN_x [18]WEN_x [17:7]A_x
//              [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load
module core_seq_ctrl #(
   parameter int COL    = 8,
   parameter int IW     = 6,
   parameter int K      = 3,
   parameter int W_BASE = 1024,
   parameter int GAP    = 10,
   parameter int DRAIN  = 36
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        core_rst,
   output logic        out_valid,
   output logic [3:0]  onij,
   output logic [33:0] inst
);

   localparam int LEN_NIJ  = IW * IW;
   localparam int LEN_KIJ  = K * K;
   localparam int OW       = IW - K + 1;
   localparam int LEN_ONIJ = OW * OW;
   localparam int ACC_LEN  = LEN_KIJ + 2;

   // Counter width covers the longest phase.
   localparam int L1      = (COL > LEN_NIJ) ? COL + 1 : LEN_NIJ + 1;
   localparam int L2      = (GAP > DRAIN) ? GAP : DRAIN;
   localparam int L3      = (L1 > L2) ? L1 : L2;
   localparam int MAX_LEN = (L3 > ACC_LEN) ? L3 : ACC_LEN;
   localparam int CW      = $clog2(MAX_LEN);
   localparam int KW      = $clog2(LEN_KIJ);

   localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

   typedef enum logic [3:0] {
      S_IDLE, S_RST, S_W_L0, S_W_LOAD, S_W_GAP, S_X_L0,
      S_EXEC, S_DRAIN, S_OF_RD, S_ACC, S_FIN
   } state_t;

   state_t        st, st_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [KW-1:0] kij, kij_n;
   logic [3:0]    o, o_n;
   int            len;
   logic          last;

   logic          busy_n, done_n, core_rst_n, out_valid_n;
   logic [3:0]    onij_n;
   logic [33:0]   inst_n;
   logic          acc, cen_p, wen_p, cen_x, wen_x;
   logic          ofifo_rd, l0_rd, l0_wr, execute, load;
   int            a_p, a_x, c_i, k_i, o_i, j;

   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= S_IDLE;
         cnt       <= '0;
         kij       <= '0;
         o         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         core_rst  <= 1'b0;
         out_valid <= 1'b0;
         onij      <= '0;
         inst      <= INST_IDLE;
      end else begin
         st        <= st_n;
         cnt       <= cnt_n;
         kij       <= kij_n;
         o         <= o_n;
         busy      <= busy_n;
         done      <= done_n;
         core_rst  <= core_rst_n;
         out_valid <= out_valid_n;
         onij      <= onij_n;
         inst      <= inst_n;
      end
   end

   // Next state: every phase is a fixed-length count, cnt is the cycle within it.
   always_comb begin
      st_n  = st;
      cnt_n = cnt + 1'b1;
      kij_n = kij;
      o_n   = o;
      case (st)
         S_RST:    len = 2;
         S_W_L0:   len = COL + 1;
         S_W_LOAD: len = COL;
         S_W_GAP:  len = GAP;
         S_X_L0:   len = LEN_NIJ + 1;
         S_EXEC:   len = LEN_NIJ;
         S_DRAIN:  len = DRAIN;
         S_OF_RD:  len = LEN_NIJ + 1;
         S_ACC:    len = ACC_LEN;
         default:  len = 1;
      endcase
      last = (int'(cnt) == len - 1);
      case (st)
         S_IDLE: begin
            cnt_n = '0;
            kij_n = '0;
            o_n   = '0;
            if (start) st_n = S_RST;
         end
         S_FIN: begin
            cnt_n = '0;
            st_n  = S_IDLE;
         end
         default: begin
            if (last) begin
               cnt_n = '0;
               case (st)
                  S_RST:    st_n = S_W_L0;
                  S_W_L0:   st_n = S_W_LOAD;
                  S_W_LOAD: st_n = S_W_GAP;
                  S_W_GAP:  st_n = S_X_L0;
                  S_X_L0:   st_n = S_EXEC;
                  S_EXEC:   st_n = S_DRAIN;
                  S_DRAIN:  st_n = S_OF_RD;
                  S_OF_RD: begin
                     if (int'(kij) == LEN_KIJ - 1) begin
                        st_n = S_ACC;
                        o_n  = '0;
                     end else begin
                        st_n  = S_RST;
                        kij_n = kij + 1'b1;
                     end
                  end
                  S_ACC: begin
                     if (int'(o) == LEN_ONIJ - 1) st_n = S_FIN;
                     else                         o_n  = o + 1'b1;
                  end
                  default:  st_n = S_IDLE;
               endcase
            end
         end
      endcase
   end

   // Outputs are decoded from the next state so that, once registered, they
   // line up with the cycle that state is live (busy rises right after start).
   always_comb begin
      busy_n      = (st_n != S_IDLE);
      done_n      = 1'b0;
      core_rst_n  = 1'b0;
      out_valid_n = 1'b0;
      onij_n      = '0;
      acc         = 1'b0;
      cen_p       = 1'b1;
      wen_p       = 1'b1;
      a_p         = 0;
      cen_x       = 1'b1;
      wen_x       = 1'b1;
      a_x         = 0;
      ofifo_rd    = 1'b0;
      l0_rd       = 1'b0;
      l0_wr       = 1'b0;
      execute     = 1'b0;
      load        = 1'b0;
      c_i         = int'(cnt_n);
      k_i         = int'(kij_n);
      o_i         = int'(o_n);
      j           = c_i - 1;
      case (st_n)
         S_RST: core_rst_n = 1'b1;
         S_W_L0: begin
            if (c_i < COL) begin
               cen_x = 1'b0;
               a_x   = W_BASE + k_i * COL + c_i;
            end
            // l0 write trails the xmem read by its one-cycle latency
            l0_wr = (c_i != 0);
         end
         S_W_LOAD: begin
            l0_rd = 1'b1;
            load  = 1'b1;
         end
         S_X_L0: begin
            if (c_i < LEN_NIJ) begin
               cen_x = 1'b0;
               a_x   = c_i;
            end
            l0_wr = (c_i != 0);
         end
         S_EXEC: begin
            l0_rd   = 1'b1;
            execute = 1'b1;
         end
         S_OF_RD: begin
            ofifo_rd = (c_i < LEN_NIJ);
            if (c_i != 0) begin
               cen_p = 1'b0;
               wen_p = 1'b0;
               a_p   = k_i * LEN_NIJ + c_i - 1;
            end
         end
         S_ACC: begin
            if (c_i == 0) begin
               core_rst_n = 1'b1;
               // previous pixel's result is on sfu_out during this clear cycle
               if (o_i != 0) begin
                  out_valid_n = 1'b1;
                  onij_n      = 4'(o_i - 1);
               end
            end else if (c_i <= LEN_KIJ) begin
               cen_p = 1'b0;
               a_p   = j * LEN_NIJ + (o_i / OW + j / K) * IW + o_i % OW + j % K;
            end
            acc = (c_i >= 2);
         end
         S_FIN: begin
            out_valid_n = 1'b1;
            onij_n      = o_n;
            done_n      = 1'b1;
         end
         default: ;
      endcase
      inst_n = {acc, cen_p, wen_p, 11'(a_p), cen_x, wen_x, 11'(a_x),
                ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
   end

endmodule
